// File: rtl/rs_br_pkg.sv
// Shared types for the branch reservation station: widths, entry layout, CDB snoop helper.
package rs_br_pkg;
    localparam int RS_BR_DEPTH  = 4;
    localparam int ROB_TAG_W    = 5;
    localparam int RS_BR_XLEN   = 32;
    localparam int RS_BR_CTRL_W = 64;
    localparam int RS_BR_AGE_W  = $clog2(RS_BR_DEPTH);
    localparam int RS_BR_IDX_W  = $clog2(RS_BR_DEPTH);

    typedef struct packed {
        logic                  ready;
        logic [ROB_TAG_W-1:0]  tag;
        logic [RS_BR_XLEN-1:0] value;
    } rs_br_opnd_t;

    typedef struct packed {
        logic                    valid;
        logic [ROB_TAG_W-1:0]    rob_tag;
        rs_br_opnd_t             rs1;
        rs_br_opnd_t             rs2;
        logic [RS_BR_CTRL_W-1:0] ctrl;
        logic [RS_BR_AGE_W-1:0]  age;
    } RS_BR_ENTRY;

    // A waiting operand whose producer tag is on the bus takes the broadcast value.
    function automatic rs_br_opnd_t opnd_snoop(input rs_br_opnd_t o,
                                               input logic cdb_valid,
                                               input logic [ROB_TAG_W-1:0] cdb_tag,
                                               input logic [RS_BR_XLEN-1:0] cdb_value);
        opnd_snoop = o;
        if (!o.ready && cdb_valid && (o.tag == cdb_tag)) begin
            opnd_snoop.ready = 1'b1;
            opnd_snoop.value = cdb_value;
        end
    endfunction
endpackage

// File: rtl/rs_br_if.sv
// Dispatch, CDB and issue signals of the branch reservation station.
interface rs_br_if;
    import rs_br_pkg::*;

    logic                    squash;
    logic                    disp_valid;
    logic [ROB_TAG_W-1:0]    disp_rob_tag;
    logic                    disp_rs1_ready;
    logic                    disp_rs2_ready;
    logic [ROB_TAG_W-1:0]    disp_rs1_tag;
    logic [ROB_TAG_W-1:0]    disp_rs2_tag;
    logic [RS_BR_XLEN-1:0]   disp_rs1_value;
    logic [RS_BR_XLEN-1:0]   disp_rs2_value;
    logic [RS_BR_CTRL_W-1:0] disp_ctrl;
    logic                    rs_full;
    logic                    cdb_valid;
    logic [ROB_TAG_W-1:0]    cdb_tag;
    logic [RS_BR_XLEN-1:0]   cdb_value;
    logic                    fu_ready;
    logic                    issue_valid;
    logic [ROB_TAG_W-1:0]    issue_rob_tag;
    logic [RS_BR_XLEN-1:0]   issue_rs1_value;
    logic [RS_BR_XLEN-1:0]   issue_rs2_value;
    logic [RS_BR_CTRL_W-1:0] issue_ctrl;

    modport master (
        output squash, disp_valid, disp_rob_tag, disp_rs1_ready, disp_rs2_ready,
               disp_rs1_tag, disp_rs2_tag, disp_rs1_value, disp_rs2_value, disp_ctrl,
               cdb_valid, cdb_tag, cdb_value, fu_ready,
        input  rs_full, issue_valid, issue_rob_tag, issue_rs1_value, issue_rs2_value, issue_ctrl
    );

    modport slave (
        input  squash, disp_valid, disp_rob_tag, disp_rs1_ready, disp_rs2_ready,
               disp_rs1_tag, disp_rs2_tag, disp_rs1_value, disp_rs2_value, disp_ctrl,
               cdb_valid, cdb_tag, cdb_value, fu_ready,
        output rs_full, issue_valid, issue_rob_tag, issue_rs1_value, issue_rs2_value, issue_ctrl
    );
endinterface

// File: rtl/rs_br_entry.sv
// One reservation-station slot: storage, CDB snoop, age tracking; state visible one cycle after write.
// Holds its contents until fired, squashed or reset; never stalls its writer.
module rs_br_entry
    import rs_br_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    squash,
    input  logic                    wr,
    input  logic                    fire,
    input  logic                    age_inc,
    input  RS_BR_ENTRY              wr_entry,
    input  logic                    cdb_valid,
    input  logic [ROB_TAG_W-1:0]    cdb_tag,
    input  logic [RS_BR_XLEN-1:0]   cdb_value,
    output logic                    valid,
    output logic                    rdy,
    output logic [RS_BR_AGE_W-1:0]  age,
    output logic [ROB_TAG_W-1:0]    rob_tag,
    output logic [RS_BR_XLEN-1:0]   rs1_value,
    output logic [RS_BR_XLEN-1:0]   rs2_value,
    output logic [RS_BR_CTRL_W-1:0] ctrl
);
    localparam logic [RS_BR_AGE_W-1:0] AGE_MAX = RS_BR_AGE_W'(RS_BR_DEPTH - 1);

    RS_BR_ENTRY ent;

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            ent <= '0;
        end else if (wr) begin
            ent       <= wr_entry;
            ent.valid <= 1'b1;
            ent.age   <= '0;
            ent.rs1   <= opnd_snoop(wr_entry.rs1, cdb_valid, cdb_tag, cdb_value);
            ent.rs2   <= opnd_snoop(wr_entry.rs2, cdb_valid, cdb_tag, cdb_value);
        end else if (fire) begin
            ent <= '0;
        end else if (ent.valid) begin
            ent.rs1 <= opnd_snoop(ent.rs1, cdb_valid, cdb_tag, cdb_value);
            ent.rs2 <= opnd_snoop(ent.rs2, cdb_valid, cdb_tag, cdb_value);
            if (age_inc && (ent.age != AGE_MAX))
                ent.age <= ent.age + 1'b1;
        end
    end

    // Readiness uses registered operand state only, so a broadcast never reaches issue combinationally.
    assign rdy       = ent.valid && ent.rs1.ready && ent.rs2.ready;
    assign valid     = ent.valid;
    assign age       = ent.age;
    assign rob_tag   = ent.rob_tag;
    assign rs1_value = ent.rs1.value;
    assign rs2_value = ent.rs2.value;
    assign ctrl      = ent.ctrl;
endmodule

// File: rtl/rs_br.sv
// Branch reservation station: dispatch into lowest free slot, issue oldest ready slot combinationally.
// Issue holds while fu_ready is low; dispatch is dropped when rs_full or squash.
module rs_br
    import rs_br_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    rs_br_if.slave   bus
);
    localparam int DEPTH = RS_BR_DEPTH;

    logic [DEPTH-1:0]        ent_valid, ent_rdy, ent_wr, ent_fire;
    logic [RS_BR_AGE_W-1:0]  ent_age       [DEPTH];
    logic [ROB_TAG_W-1:0]    ent_rob_tag   [DEPTH];
    logic [RS_BR_XLEN-1:0]   ent_rs1_value [DEPTH];
    logic [RS_BR_XLEN-1:0]   ent_rs2_value [DEPTH];
    logic [RS_BR_CTRL_W-1:0] ent_ctrl      [DEPTH];

    RS_BR_ENTRY              wr_entry;
    logic                    accept, fire, sel_found;
    logic [RS_BR_IDX_W-1:0]  free_idx, sel_idx;
    logic [RS_BR_AGE_W-1:0]  sel_age;

    assign bus.rs_full = &ent_valid;
    assign accept      = bus.disp_valid && !bus.rs_full && !bus.squash;

    always_comb begin
        wr_entry           = '0;
        wr_entry.valid     = 1'b1;
        wr_entry.rob_tag   = bus.disp_rob_tag;
        wr_entry.rs1.ready = bus.disp_rs1_ready;
        wr_entry.rs1.tag   = bus.disp_rs1_tag;
        wr_entry.rs1.value = bus.disp_rs1_value;
        wr_entry.rs2.ready = bus.disp_rs2_ready;
        wr_entry.rs2.tag   = bus.disp_rs2_tag;
        wr_entry.rs2.value = bus.disp_rs2_value;
        wr_entry.ctrl      = bus.disp_ctrl;
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!ent_valid[i]) free_idx = RS_BR_IDX_W'(i);
    end

    // Strict compare keeps the lowest index should two ages ever coincide.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_rdy[i] && (!sel_found || (ent_age[i] > sel_age))) begin
                sel_found = 1'b1;
                sel_idx   = RS_BR_IDX_W'(i);
                sel_age   = ent_age[i];
            end
        end
    end

    assign bus.issue_valid = sel_found && !bus.squash;
    assign fire            = bus.issue_valid && bus.fu_ready;

    always_comb begin
        ent_wr   = '0;
        ent_fire = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_wr[i]   = accept && (free_idx == RS_BR_IDX_W'(i));
            ent_fire[i] = fire && (sel_idx == RS_BR_IDX_W'(i));
        end
    end

    assign bus.issue_rob_tag   = bus.issue_valid ? ent_rob_tag[sel_idx]   : '0;
    assign bus.issue_rs1_value = bus.issue_valid ? ent_rs1_value[sel_idx] : '0;
    assign bus.issue_rs2_value = bus.issue_valid ? ent_rs2_value[sel_idx] : '0;
    assign bus.issue_ctrl      = bus.issue_valid ? ent_ctrl[sel_idx]      : '0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        rs_br_entry u_entry (
            .clock     (clock),
            .reset     (reset),
            .squash    (bus.squash),
            .wr        (ent_wr[g]),
            .fire      (ent_fire[g]),
            .age_inc   (accept),
            .wr_entry  (wr_entry),
            .cdb_valid (bus.cdb_valid),
            .cdb_tag   (bus.cdb_tag),
            .cdb_value (bus.cdb_value),
            .valid     (ent_valid[g]),
            .rdy       (ent_rdy[g]),
            .age       (ent_age[g]),
            .rob_tag   (ent_rob_tag[g]),
            .rs1_value (ent_rs1_value[g]),
            .rs2_value (ent_rs2_value[g]),
            .ctrl      (ent_ctrl[g])
        );
    end
endmodule

// File: tb/tb_rs_br.sv
// Directed and random checks of rs_br against a slot-level model of the reservation-station rules.
module tb_rs_br;
    import rs_br_pkg::*;

    localparam int D = RS_BR_DEPTH;

    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    rs_br_if bus ();
    rs_br dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // Model: one record per slot, following the dispatch/snoop/age/select rules directly.
    bit        mv  [D];
    bit [4:0]  mtag[D];
    bit        mr1 [D], mr2[D];
    bit [4:0]  mt1 [D], mt2[D];
    bit [31:0] mx1 [D], mx2[D];
    bit [63:0] mc  [D];
    int        mage[D];
    bit [4:0]  issued[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < D; i++) begin
            mv[i] = 0; mage[i] = 0;
        end
    endfunction

    function automatic bit model_full();
        model_full = 1;
        for (int i = 0; i < D; i++) if (!mv[i]) model_full = 0;
    endfunction

    function automatic int model_sel();
        model_sel = -1;
        for (int i = 0; i < D; i++)
            if (mv[i] && mr1[i] && mr2[i] && (model_sel < 0 || mage[i] > mage[model_sel]))
                model_sel = i;
    endfunction

    task automatic model_edge();
        int sel, fr;
        bit acc, fir;
        if (reset || bus.squash) begin
            model_clear();
        end else begin
            sel = model_sel();
            fir = (sel >= 0) && bus.fu_ready;
            acc = bus.disp_valid && !model_full();
            fr  = -1;
            for (int i = 0; i < D; i++) if (!mv[i] && fr < 0) fr = i;
            for (int i = 0; i < D; i++) begin
                if (mv[i]) begin
                    if (!mr1[i] && bus.cdb_valid && mt1[i] == bus.cdb_tag) begin mr1[i] = 1; mx1[i] = bus.cdb_value; end
                    if (!mr2[i] && bus.cdb_valid && mt2[i] == bus.cdb_tag) begin mr2[i] = 1; mx2[i] = bus.cdb_value; end
                    if (acc && mage[i] < D - 1) mage[i]++;
                end
            end
            if (fir) mv[sel] = 0;
            if (acc) begin
                mv[fr] = 1; mage[fr] = 0; mtag[fr] = bus.disp_rob_tag; mc[fr] = bus.disp_ctrl;
                mr1[fr] = bus.disp_rs1_ready; mt1[fr] = bus.disp_rs1_tag; mx1[fr] = bus.disp_rs1_value;
                mr2[fr] = bus.disp_rs2_ready; mt2[fr] = bus.disp_rs2_tag; mx2[fr] = bus.disp_rs2_value;
                if (!mr1[fr] && bus.cdb_valid && mt1[fr] == bus.cdb_tag) begin mr1[fr] = 1; mx1[fr] = bus.cdb_value; end
                if (!mr2[fr] && bus.cdb_valid && mt2[fr] == bus.cdb_tag) begin mr2[fr] = 1; mx2[fr] = bus.cdb_value; end
            end
        end
    endtask

    // Inputs are set just after a rising edge; outputs are compared on the falling edge.
    task automatic cycle();
        int  s;
        bit  ev;
        #4;
        s  = model_sel();
        ev = (s >= 0) && !bus.squash;
        chk("rs_full", bus.rs_full, model_full());
        chk("issue_valid", bus.issue_valid, ev);
        chk("issue_rob_tag", bus.issue_rob_tag, ev ? mtag[s] : 0);
        chk("issue_rs1", bus.issue_rs1_value, ev ? mx1[s] : 0);
        chk("issue_rs2", bus.issue_rs2_value, ev ? mx2[s] : 0);
        chk("issue_ctrl", bus.issue_ctrl, ev ? mc[s] : 0);
        if (bus.issue_valid === 1'b1 && bus.fu_ready) issued.push_back(bus.issue_rob_tag);
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic disp(input logic [4:0] tag, input logic r1, input logic [4:0] t1, input logic [31:0] x1,
                        input logic r2, input logic [4:0] t2, input logic [31:0] x2);
        bus.disp_valid = 1; bus.disp_rob_tag = tag;
        bus.disp_rs1_ready = r1; bus.disp_rs1_tag = t1; bus.disp_rs1_value = x1;
        bus.disp_rs2_ready = r2; bus.disp_rs2_tag = t2; bus.disp_rs2_value = x2;
        bus.disp_ctrl = {$urandom, $urandom};
    endtask

    task automatic idle();
        bus.disp_valid = 0;
    endtask

    task automatic cdb(input logic v, input logic [4:0] t, input logic [31:0] x);
        bus.cdb_valid = v; bus.cdb_tag = t; bus.cdb_value = x;
    endtask

    task automatic chk_order(input string tag, input bit [4:0] a, input bit [4:0] b);
        chk({tag, "_cnt"}, issued.size(), 2);
        if (issued.size() >= 2) begin
            chk({tag, "_0"}, issued[0], a);
            chk({tag, "_1"}, issued[1], b);
        end
    endtask

    initial begin
        reset = 1; bus.squash = 0; bus.fu_ready = 0;
        idle(); disp(0, 0, 0, 0, 0, 0, 0); idle(); cdb(0, 0, 0);
        model_clear();
        @(posedge clock); #1;
        cycle(); cycle();
        reset = 0;

        // Both operands ready: issues the cycle after dispatch.
        bus.fu_ready = 1;
        disp(3, 1, 0, 32'h10, 1, 0, 32'h10); cycle(); idle();
        chk("t1_iv", bus.issue_valid, 1);
        chk("t1_tag", bus.issue_rob_tag, 3);
        chk("t1_rs1", bus.issue_rs1_value, 32'h10);
        cycle(); cycle();
        chk("t1_freed", bus.issue_valid, 0);

        // rs1 waits on tag 9.
        disp(4, 0, 9, 0, 1, 0, 32'h22); cycle(); idle(); cycle();
        cdb(1, 9, 32'hABCD); cycle(); cdb(0, 0, 0);
        chk("t2_iv", bus.issue_valid, 1);
        chk("t2_rs1", bus.issue_rs1_value, 32'hABCD);
        cycle();

        // Dispatch-cycle bypass of rs2.
        disp(8, 1, 0, 32'h1, 0, 7, 0); cdb(1, 7, 32'h55); cycle(); idle(); cdb(0, 0, 0);
        chk("t3_iv", bus.issue_valid, 1);
        chk("t3_rs2", bus.issue_rs2_value, 32'h55);
        cycle();

        // Fill, drop fifth, drain oldest first.
        bus.fu_ready = 0;
        for (int t = 1; t <= 4; t++) begin disp(5'(t), 1, 0, 32'(t), 1, 0, 32'(t)); cycle(); end
        chk("t4_full", bus.rs_full, 1);
        disp(5, 1, 0, 0, 1, 0, 0); cycle(); idle();
        issued.delete();
        bus.fu_ready = 1;
        repeat (5) cycle();
        chk("t4_cnt", issued.size(), 4);
        for (int k = 0; k < 4 && k < issued.size(); k++) chk("t4_order", issued[k], 5'(k + 1));

        // Younger entry ready first issues first.
        issued.delete();
        disp(5, 0, 10, 0, 1, 0, 1); cycle();
        disp(6, 0, 11, 0, 1, 0, 2); cycle(); idle();
        cdb(1, 11, 32'h66); cycle(); cdb(0, 0, 0); cycle();
        cdb(1, 10, 32'h55); cycle(); cdb(0, 0, 0); cycle(); cycle();
        chk_order("t5a", 6, 5);

        // Both ready while stalled: older wins.
        issued.delete(); bus.fu_ready = 0;
        disp(5, 0, 12, 0, 1, 0, 1); cycle();
        disp(6, 0, 13, 0, 1, 0, 2); cycle(); idle();
        cdb(1, 13, 32'h13); cycle(); cdb(1, 12, 32'h12); cycle(); cdb(0, 0, 0);
        bus.fu_ready = 1; repeat (3) cycle();
        chk_order("t5b", 5, 6);

        // Squash with three entries and a concurrent dispatch.
        bus.fu_ready = 0;
        for (int t = 20; t < 23; t++) begin disp(5'(t), 1, 0, 1, 1, 0, 1); cycle(); end
        disp(23, 1, 0, 1, 1, 0, 1); bus.squash = 1; cycle(); bus.squash = 0; idle();
        chk("t6_full", bus.rs_full, 0);
        chk("t6_iv", bus.issue_valid, 0);
        issued.delete(); bus.fu_ready = 1; repeat (2) cycle();
        chk("t6_none", issued.size(), 0);

        // Reset mid-fill.
        bus.fu_ready = 0;
        disp(1, 1, 0, 1, 1, 0, 1); cycle(); disp(2, 1, 0, 2, 1, 0, 2); cycle();
        disp(3, 1, 0, 3, 1, 0, 3); reset = 1; cycle(); reset = 0; idle();
        chk("t7_full", bus.rs_full, 0);
        chk("t7_iv", bus.issue_valid, 0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 1) == 1)
                disp(5'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                     1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            else
                idle();
            cdb($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom);
            bus.fu_ready = ($urandom_range(0, 9) < 6);
            bus.squash   = ($urandom_range(0, 49) == 0);
            reset        = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 0; bus.squash = 0; idle(); cdb(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
